// File: rtl/fsm_cmd_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : fsm_cmd_issuer
//  Purpose  : Accepts host state-change requests, validates the requested code
//             and the transition against the last acknowledged state, then
//             issues the command to a downstream FSM with a valid/ack
//             handshake guarded by a timeout. Errors are sticky. The first
//             cause is kept until err_clr.
//  Ports    : clk          - single clock, rising edge
//             rst_n        - synchronous reset, ACTIVE HIGH despite its name
//             i_req_valid  - host request present
//             i_req_code   - requested target state code
//             o_req_ready  - request accepted this cycle (only in S_IDLE)
//             o_cmd_valid  - command presented downstream
//             o_cmd_code   - command code (0 while o_cmd_valid is 0)
//             i_cmd_ack    - downstream has taken the command
//             i_err_clr    - clears the error status
//             o_cur_state  - last acknowledged code
//             o_err        - sticky error flag
//             o_err_code   - first error cause since the last clear
//                            (1 illegal code, 2 bad transition, 3 timeout,
//                             4 corrupt FSM state)
//  Revision : 1.0 - initial release
// ============================================================================
module fsm_cmd_issuer #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_req_valid,
  input  logic [2:0] i_req_code,
  output logic       o_req_ready,
  output logic       o_cmd_valid,
  output logic [2:0] o_cmd_code,
  input  logic       i_cmd_ack,
  input  logic       i_err_clr,
  output logic [2:0] o_cur_state,
  output logic       o_err,
  output logic [2:0] o_err_code
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHECK     = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_DROP = 3'd3,
    S_ERR       = 3'd4
  } state_e;

  localparam logic [2:0] c_CODE_IDLE  = 3'd0;
  localparam logic [2:0] c_CODE_LOAD  = 3'd1;
  localparam logic [2:0] c_CODE_RUN   = 3'd2;
  localparam logic [2:0] c_CODE_PAUSE = 3'd3;
  localparam logic [2:0] c_CODE_DONE  = 3'd4;

  localparam logic [2:0] c_ERR_ILLEGAL = 3'd1;
  localparam logic [2:0] c_ERR_TRANS   = 3'd2;
  localparam logic [2:0] c_ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] c_ERR_STATE   = 3'd4;

  // The counter runs 0,1,2,... while waiting; the cycle in which it would
  // reach TIMEOUT is the last one an ack is still honoured.
  localparam logic [3:0] c_CNT_LAST = 4'(TIMEOUT - 1);

  // State is kept as plain bits so the three unused encodings stay
  // representable and can be decoded explicitly.
  logic [2:0] r_state;
  logic [2:0] r_code;
  logic [3:0] r_cnt;
  logic       r_req_ready;
  logic       r_cmd_valid;
  logic [2:0] r_cmd_code;
  logic [2:0] r_cur_state;
  logic       r_err;
  logic [2:0] r_err_code;

  logic       w_code_legal;
  logic       w_trans_ok;
  logic       w_noop;
  logic       w_raise;
  logic [2:0] w_cause;

  assign w_code_legal = (r_code <= c_CODE_DONE);
  assign w_noop       = (r_code == r_cur_state);

  // Allowed transition table; abort to IDLE is legal from anywhere.
  always_comb begin
    w_trans_ok = 1'b0;
    if (r_code == c_CODE_IDLE) begin
      w_trans_ok = 1'b1;
    end else begin
      case (r_cur_state)
        c_CODE_IDLE:  w_trans_ok = (r_code == c_CODE_LOAD);
        c_CODE_LOAD:  w_trans_ok = (r_code == c_CODE_RUN);
        c_CODE_RUN:   w_trans_ok = (r_code == c_CODE_PAUSE) || (r_code == c_CODE_DONE);
        c_CODE_PAUSE: w_trans_ok = (r_code == c_CODE_RUN);
        default:      w_trans_ok = 1'b0;
      endcase
    end
  end

  // Error raised by the current cycle, if any.
  always_comb begin
    w_raise = 1'b0;
    w_cause = 3'd0;
    case (r_state)
      S_CHECK: begin
        if (!w_code_legal) begin
          w_raise = 1'b1;
          w_cause = c_ERR_ILLEGAL;
        end else if (!w_noop && !w_trans_ok) begin
          w_raise = 1'b1;
          w_cause = c_ERR_TRANS;
        end
      end
      S_ISSUE: begin
        if (!i_cmd_ack && (r_cnt == c_CNT_LAST)) begin
          w_raise = 1'b1;
          w_cause = c_ERR_TIMEOUT;
        end
      end
      S_IDLE, S_WAIT_DROP, S_ERR: begin
        w_raise = 1'b0;
      end
      3'd5, 3'd6, 3'd7: begin
        w_raise = 1'b1;
        w_cause = c_ERR_STATE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state     <= S_IDLE;
      r_code      <= 3'd0;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b1;
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= 3'd0;
      r_cur_state <= 3'd0;
      r_err       <= 1'b0;
      r_err_code  <= 3'd0;
    end else begin
      // A new error beats a simultaneous clear; otherwise the first cause
      // is preserved until cleared.
      if (w_raise) begin
        r_err <= 1'b1;
        if (!r_err || i_err_clr) begin
          r_err_code <= w_cause;
        end
      end else if (i_err_clr) begin
        r_err      <= 1'b0;
        r_err_code <= 3'd0;
      end

      case (r_state)
        S_IDLE: begin
          if (i_req_valid && r_req_ready) begin
            r_code      <= i_req_code;
            r_state     <= S_CHECK;
            r_req_ready <= 1'b0;
          end
        end
        S_CHECK: begin
          if (w_raise || w_noop) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
          end else begin
            r_state     <= S_ISSUE;
            r_cmd_valid <= 1'b1;
            r_cmd_code  <= r_code;
            r_cnt       <= 4'd0;
          end
        end
        S_ISSUE: begin
          if (i_cmd_ack) begin
            r_cur_state <= r_code;
            r_state     <= S_WAIT_DROP;
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= 3'd0;
          end else if (w_raise) begin
            r_state     <= S_ERR;
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= 3'd0;
            r_cnt       <= r_cnt + 4'd1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_WAIT_DROP: begin
          if (!i_cmd_ack) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
          end
        end
        S_ERR: begin
          if (i_err_clr) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
          end
        end
        3'd5, 3'd6, 3'd7: begin
          r_state     <= S_ERR;
          r_req_ready <= 1'b0;
          r_cmd_valid <= 1'b0;
          r_cmd_code  <= 3'd0;
        end
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_cmd_valid = r_cmd_valid;
  assign o_cmd_code  = r_cmd_code;
  assign o_cur_state = r_cur_state;
  assign o_err       = r_err;
  assign o_err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_fsm_cmd_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fsm_cmd_issuer
//  Purpose  : Self-checking bench for fsm_cmd_issuer (TIMEOUT = 4). A table of
//             per-cycle input/expected-output records, followed by hand-written
//             sequences for state corruption and issue latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_cmd_issuer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_code = 3'd0;
  logic       req_ready;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_ack = 1'b0;
  logic       err_clr = 1'b0;
  logic [2:0] cur_state;
  logic       err;
  logic [2:0] err_code;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fsm_cmd_issuer #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (req_valid),
    .i_req_code  (req_code),
    .o_req_ready (req_ready),
    .o_cmd_valid (cmd_valid),
    .o_cmd_code  (cmd_code),
    .i_cmd_ack   (cmd_ack),
    .i_err_clr   (err_clr),
    .o_cur_state (cur_state),
    .o_err       (err),
    .o_err_code  (err_code)
  );

  typedef struct {
    logic       rst;
    logic       rv;
    logic [2:0] rc;
    logic       ack;
    logic       clr;
    logic       rdy;
    logic       cv;
    logic [2:0] cc;
    logic [2:0] cs;
    logic       e;
    logic [2:0] ec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int rst, rv, rc, ack, clr,
                              rdy, cv, cc, cs, e, ec);
    vec_t r;
    r.rst = 1'(rst); r.rv = 1'(rv); r.rc = 3'(rc); r.ack = 1'(ack); r.clr = 1'(clr);
    r.rdy = 1'(rdy); r.cv = 1'(cv); r.cc = 3'(cc); r.cs = 3'(cs); r.e = 1'(e); r.ec = 3'(ec);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Output snapshot packed as {rdy, cv, cc, cs, err, ec}
  function automatic logic [31:0] outs();
    return {20'd0, req_ready, cmd_valid, cmd_code, cur_state, err, err_code};
  endfunction

  initial begin
    int lat;
    //            rst rv rc ack clr | rdy cv cc cs e ec
    vecs.push_back(mk(1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0)); // 0 reset
    vecs.push_back(mk(1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0)); // 1 reset
    vecs.push_back(mk(0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0)); // 2 accept 1
    vecs.push_back(mk(0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0)); // 3 issue, 2 cycles later
    vecs.push_back(mk(0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0)); // 4 held
    vecs.push_back(mk(0, 0, 0, 1, 0,   0, 0, 0, 1, 0, 0)); // 5 ack
    vecs.push_back(mk(0, 0, 0, 1, 0,   0, 0, 0, 1, 0, 0)); // 6 wait drop
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0)); // 7 idle
    vecs.push_back(mk(0, 1, 6, 0, 0,   0, 0, 0, 1, 0, 0)); // 8 illegal 6
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 1)); // 9 err 1
    vecs.push_back(mk(0, 0, 0, 0, 1,   1, 0, 0, 1, 0, 0)); // 10 clear
    vecs.push_back(mk(0, 1, 3, 0, 0,   0, 0, 0, 1, 0, 0)); // 11 1->3
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 2)); // 12 err 2
    vecs.push_back(mk(0, 1, 5, 0, 0,   0, 0, 0, 1, 1, 2)); // 13 illegal 5
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 2)); // 14 first cause kept
    vecs.push_back(mk(0, 1, 0, 0, 1,   0, 0, 0, 1, 0, 0)); // 15 abort + clear
    vecs.push_back(mk(0, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0)); // 16 issue code 0
    vecs.push_back(mk(0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0)); // 17 ack
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0)); // 18 idle
    vecs.push_back(mk(0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0)); // 19 noop 0
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0)); // 20 back idle
    vecs.push_back(mk(0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0)); // 21 accept 1
    vecs.push_back(mk(0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0)); // 22 issue cnt0
    vecs.push_back(mk(0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0)); // 23 cnt1
    vecs.push_back(mk(0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0)); // 24 cnt2
    vecs.push_back(mk(0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0)); // 25 cnt3
    vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 3)); // 26 timeout
    vecs.push_back(mk(0, 1, 1, 1, 0,   0, 0, 0, 0, 1, 3)); // 27 err holds
    vecs.push_back(mk(0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0)); // 28 err_clr
    vecs.push_back(mk(0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0)); // 29 accept 1
    vecs.push_back(mk(0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0)); // 30 issue
    vecs.push_back(mk(0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0)); // 31
    vecs.push_back(mk(0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0)); // 32
    vecs.push_back(mk(0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0)); // 33
    vecs.push_back(mk(0, 0, 0, 1, 0,   0, 0, 0, 1, 0, 0)); // 34 ack at limit
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0)); // 35 idle
    vecs.push_back(mk(0, 1, 7, 0, 0,   0, 0, 0, 1, 0, 0)); // 36 illegal 7
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 1)); // 37 err 1
    vecs.push_back(mk(0, 1, 4, 0, 0,   0, 0, 0, 1, 1, 1)); // 38 1->4
    vecs.push_back(mk(0, 0, 0, 0, 1,   1, 0, 0, 1, 1, 2)); // 39 new err beats clr
    vecs.push_back(mk(0, 1, 2, 0, 0,   0, 0, 0, 1, 1, 2)); // 40 1->2
    vecs.push_back(mk(0, 0, 0, 0, 0,   0, 1, 2, 1, 1, 2)); // 41 issue
    vecs.push_back(mk(1, 0, 0, 1, 0,   1, 0, 0, 0, 0, 0)); // 42 reset mid issue
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0)); // 43 idle

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n     = vecs[i].rst;
      req_valid = vecs[i].rv;
      req_code  = vecs[i].rc;
      cmd_ack   = vecs[i].ack;
      err_clr   = vecs[i].clr;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), outs(),
            {20'd0, vecs[i].rdy, vecs[i].cv, vecs[i].cc, vecs[i].cs, vecs[i].e, vecs[i].ec});
    end

    // Corrupt the state register with an unused encoding.
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b0; cmd_ack = 1'b0; err_clr = 1'b0;
    force dut.r_state = 3'd5;
    @(posedge clk);
    #1;
    release dut.r_state;
    check("bad_state_err", {29'd0, err, err_code}, {29'd0, 1'b1, 3'd4});
    check("bad_state_rdy", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("s_err_hold", {28'd0, req_ready, cmd_valid, err, 1'b0}, {28'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    check("bad_state_clr", {28'd0, req_ready, err, err_code}, {28'd0, 1'b1, 1'b0, 3'd0});

    // Issue latency: cmd_valid two cycles after acceptance, bounded wait.
    @(negedge clk);
    err_clr = 1'b0; req_valid = 1'b1; req_code = 3'd1;
    @(posedge clk);
    #1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (cmd_valid) begin
        lat = k + 1;
        break;
      end
    end
    if (lat == 0) begin
      n_checks++;
      $display("FAIL issue_latency: got no cmd_valid within 8 cycles, want 2");
    end else begin
      check("issue_latency", lat, 32'd2);
    end
    @(negedge clk);
    cmd_ack = 1'b1;
    @(posedge clk);
    #1;
    check("latency_ack", {29'd0, cmd_valid, cur_state}, {29'd0, 1'b0, 3'd1});
    @(negedge clk);
    cmd_ack = 1'b0;
    @(posedge clk);
    #1;
    check("latency_idle", {31'd0, req_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fsm_cmd_issuer.md
FSM_CMD_ISSUER -- requirements
Module: fsm_cmd_issuer

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum cycles cmd_valid is held without cmd_ack (range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, a synchronous active-high reset: 1 sampled at a clk edge resets the block.
REQ-004 The block SHALL have port req_valid, input, 1, meaning a host request is present.
REQ-005 The block SHALL have port req_code, input, 3, the requested target state code.
REQ-006 The block SHALL have port req_ready, output, 1, meaning the block accepts a request this cycle.
REQ-007 The block SHALL have port cmd_valid, output, 1, meaning a command is presented to the downstream FSM.
REQ-008 The block SHALL have port cmd_code, output, 3, the command code driven to the downstream FSM.
REQ-009 The block SHALL have port cmd_ack, input, 1, meaning the downstream FSM has taken the command.
REQ-010 The block SHALL have port err_clr, input, 1, which clears the error status.
REQ-011 The block SHALL have port cur_state, output, 3, a mirror of the last acknowledged code.
REQ-012 The block SHALL have port err, output, 1, a sticky error flag.
REQ-013 The block SHALL have port err_code, output, 3, the cause of the first error since the last clear.

Function
REQ-014 Legal codes SHALL be 0 IDLE, 1 LOAD, 2 RUN, 3 PAUSE and 4 DONE; codes 5..7 are illegal.
REQ-015 Allowed transitions from cur_state SHALL be 0->1, 1->2, 2->3, 3->2, 2->4, 4->0, and any->0 (abort).
REQ-016 A request whose code equals cur_state SHALL be accepted as a no-op: no command is issued, no error is raised, and the block returns to S_IDLE.
REQ-017 The control FSM SHALL have states S_IDLE, S_CHECK, S_ISSUE, S_WAIT_DROP and S_ERR, held in a 3-bit register.
REQ-018 The three unused encodings SHALL be decoded explicitly; any of them in the next cycle enters S_ERR with err_code=4.
REQ-019 req_ready SHALL be 1 only in S_IDLE.
REQ-020 A request SHALL be captured on req_valid&&req_ready; the FSM then enters S_CHECK on the next cycle.
REQ-021 If the captured code is illegal, S_CHECK SHALL set err=1 and err_code=1, then return to S_IDLE without issuing a command.
REQ-022 If the captured transition is not allowed, S_CHECK SHALL set err=1 and err_code=2, then return to S_IDLE without issuing a command.
REQ-023 If the captured code is legal and the transition is allowed, S_CHECK SHALL go to S_ISSUE, so cmd_valid=1 two cycles after acceptance.
REQ-024 In S_ISSUE, cmd_valid SHALL be 1 and cmd_code SHALL hold the captured code, both stable until cmd_ack.
REQ-025 A 4-bit counter SHALL clear on entry to S_ISSUE and increment each cycle in S_ISSUE without cmd_ack.
REQ-026 cmd_ack in S_ISSUE SHALL update cur_state to the captured code and move the FSM to S_WAIT_DROP; cmd_valid is 0 from the next cycle.
REQ-027 S_WAIT_DROP SHALL stay until cmd_ack=0, then go to S_IDLE.
REQ-028 When the counter reaches TIMEOUT without cmd_ack, the FSM SHALL go to S_ERR with err=1 and err_code=3, leaving cur_state unchanged.
REQ-029 cmd_ack arriving in the same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-030 In S_ERR, req_ready and cmd_valid SHALL be 0, and the FSM leaves only on err_clr=1, going to S_IDLE.
REQ-031 err_clr in any state SHALL clear err and err_code to 0 unless a new error is raised in the same cycle, in which case the new error wins.
REQ-032 err_code SHALL hold the first error cause; later errors before a clear leave it unchanged.
REQ-033 cmd_ack outside S_ISSUE SHALL be ignored.
REQ-034 cmd_code SHALL be 0 whenever cmd_valid is 0.

Reset
REQ-035 rst_n=1 SHALL force, at the next clk edge, FSM=S_IDLE, cur_state=0, cmd_valid=0, cmd_code=0, counter=0, err=0, err_code=0 and req_ready=1 after release.
REQ-036 Reset SHALL override every other input, including in the middle of an S_ISSUE handshake; the pending command is dropped and no ack is recorded.

Verification
REQ-037 The bench SHALL check: after reset, request 1 with cmd_ack one cycle after cmd_valid -> cmd_valid rises 2 cycles after acceptance, cur_state=1, err=0.
REQ-038 The bench SHALL check: from cur_state=1, request 6 -> no cmd_valid, err=1, err_code=1, req_ready=1 again after 2 cycles.
REQ-039 The bench SHALL check: from cur_state=1, request 3 -> err_code=2 and cur_state stays 1; a later request 0 then issues cmd_code=0.
REQ-040 The bench SHALL check: TIMEOUT=4 with cmd_ack held low -> S_ERR after 4 cycles in S_ISSUE, err_code=3, req_ready=0 until err_clr.
REQ-041 The bench SHALL check: force the state register to an unused encoding -> next cycle S_ERR with err_code=4, and err_clr returns the FSM to S_IDLE.
REQ-042 The bench SHALL check: rst_n=1 while cmd_valid=1 -> next cycle cmd_valid=0, cur_state=0, err=0.
